// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// wb_arbiter_pkg : shared widths, FIFO entry type and write-source encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int MXLEN    = 32;
    localparam int REG_NUM  = 32;
    localparam int WB_DEPTH = 4;
    localparam int RD_W     = 5;

    typedef struct packed {
        logic [RD_W-1:0]  rd;
        logic [MXLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

    function automatic logic [REG_NUM-1:0] rd_onehot(input logic [RD_W-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// wb_fifo : synchronous FIFO of {rd, data} long-latency results
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic      CLK,
    input  logic      RST_N,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so a full queue differs from an empty one.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    wb_entry_t   mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : register-file write-port arbiter (ALU / LL FIFO / LL bypass)
//              with per-register busy scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               alu_valid,
    input  logic [RD_W-1:0]    alu_rd,
    input  logic [MXLEN-1:0]   alu_data,
    input  logic               exception,
    input  logic               ll_valid,
    output logic               ll_ready,
    input  logic [RD_W-1:0]    ll_rd,
    input  logic [MXLEN-1:0]   ll_data,
    input  logic               issue_valid,
    input  logic [RD_W-1:0]    issue_rd,
    output logic [REG_NUM-1:0] busy,
    output logic [RD_W-1:0]    w_addr,
    output logic               reg_write,
    output logic [MXLEN-1:0]   w_data
);

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    wb_entry_t    fifo_head;
    wb_entry_t    ll_entry;
    wb_entry_t    sel;
    wb_src_e      src;
    logic         ll_xfer;
    logic         alu_ok;
    logic [REG_NUM-1:0] busy_set;
    logic [REG_NUM-1:0] busy_clr;
    logic [REG_NUM-1:0] busy_next;

    assign ll_ready = !fifo_full;
    assign ll_xfer  = ll_valid && ll_ready;
    assign alu_ok   = alu_valid && !exception && (alu_rd != '0);
    assign ll_entry = '{rd: ll_rd, data: ll_data};

    always_comb begin
        src = SRC_NONE;
        if (alu_ok)
            src = SRC_ALU;
        else if (!fifo_empty)
            src = SRC_FIFO;
        else if (ll_xfer && (ll_rd != '0))
            src = SRC_BYPASS;
    end

    // rd=0 transfers complete the handshake but are never queued.
    assign fifo_pop  = (src == SRC_FIFO);
    assign fifo_push = ll_xfer && (ll_rd != '0) && (src != SRC_BYPASS);

    always_comb begin
        sel = '0;
        case (src)
            SRC_ALU:    sel = '{rd: alu_rd, data: alu_data};
            SRC_FIFO:   sel = fifo_head;
            SRC_BYPASS: sel = ll_entry;
            default:    sel = '0;
        endcase
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_valid && (issue_rd != '0))
            busy_set = rd_onehot(issue_rd);
        if (src == SRC_FIFO || src == SRC_BYPASS)
            busy_clr = rd_onehot(sel.rd);
        // A re-issue of the retiring rd keeps it busy.
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_write <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            busy      <= '0;
        end else begin
            reg_write <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                w_addr <= sel.rd;
                w_data <= sel.data;
            end
            busy <= busy_next;
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (fifo_push),
        .push_entry (ll_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

`default_nettype wire
